// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// State encoding and counter sizing used by seq_pattern_tx.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    // Minimum bits needed to count 0..v-1; evaluated at elaboration only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial output bundle of seq_pattern_tx.
// master = pattern source, slave = transmitter.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [REP_W-1:0] load_reps;
    logic             data_out;
    logic             data_vld;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, load_reps,
        input  load_ready, data_out, data_vld, busy, done
    );

    modport slave (
        input  load_valid, load_data, load_reps,
        output load_ready, data_out, data_vld, busy, done
    );
endinterface

// File: rtl/seq_tx_shreg.sv
// WIDTH-bit loadable left-shift register; MSB is the serial output.
// Zeros shift in, so the register is empty once a pattern has fully drained.
module seq_tx_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg[WIDTH-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: MSB-first, repeated load_reps+1 times back-to-back.
// Optional even-parity bit after each repetition when SEQ_TX_PARITY_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for a load; load_ready high, outputs quiet
// ST_SEND | shifting pattern bits out, one per clk
// ST_PAR  | sending the parity bit of the held pattern (macro only)
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_pattern_tx_if.slave bus
);
    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold;
    logic [CNT_W-1:0] bit_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic             accept;
    logic             bit_end;
    logic             rep_end;
    logic             reload;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb;

    assign accept  = bus.load_valid && bus.load_ready;
    assign bit_end = (bit_cnt == '0);
    assign rep_end = (rep_cnt == '0);

`ifdef SEQ_TX_PARITY_EN
    assign reload = (state == ST_PAR) && !rep_end;
`else
    assign reload = (state == ST_SEND) && bit_end && !rep_end;
`endif

    assign sh_load  = accept || reload;
    assign sh_shift = (state == ST_SEND);
    assign sh_din   = accept ? bus.load_data : hold;

    seq_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SEND;
            end
`ifdef SEQ_TX_PARITY_EN
            ST_SEND: begin
                if (bit_end) state_nxt = ST_PAR;
            end
            ST_PAR: begin
                state_nxt = rep_end ? ST_IDLE : ST_SEND;
            end
`else
            ST_SEND: begin
                if (bit_end && rep_end) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters and pattern holding register; the rep counter only decrements
    // while non-zero, so an all-ones load yields 2^REP_W passes without underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold    <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
        end else if (accept) begin
            hold    <= bus.load_data;
            bit_cnt <= BIT_LAST;
            rep_cnt <= bus.load_reps;
        end else if (state == ST_SEND && !bit_end) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
        end else if (reload) begin
            bit_cnt <= BIT_LAST;
            rep_cnt <= rep_cnt - REP_W'(1);
        end
    end

    always_comb begin
        bus.load_ready = (state == ST_IDLE) && !rst;
        bus.busy       = (state != ST_IDLE);
        bus.data_vld   = (state == ST_SEND) || (state == ST_PAR);
        bus.data_out   = sh_msb && (state == ST_SEND);
`ifdef SEQ_TX_PARITY_EN
        if (state == ST_PAR) bus.data_out = ^hold;
        bus.done = (state == ST_PAR) && rep_end;
`else
        bus.done = (state == ST_SEND) && bit_end && rep_end;
`endif
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with an expected-bit scoreboard.
// Honours SEQ_TX_PARITY_EN to build the matching reference stream.
module tb_seq_pattern_tx;
    localparam int W = 4;
    localparam int R = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_pattern_tx_if #(.WIDTH(W), .REP_W(R)) bus ();

    seq_pattern_tx #(.WIDTH(W), .REP_W(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         vld_cnt = 0;
    int         det_cnt = 0;
    logic [3:0] hist = 4'd0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score whatever the DUT is presenting.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.data_vld === 1'b1) begin
            vld_cnt++;
            hist = {hist[2:0], bus.data_out};
            if (vld_cnt >= 4 && hist == 4'b1010) det_cnt++;
            chk_int("vld_has_expected_bit", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("stream_bit", bus.data_out, e.b);
                chk("done_align", bus.done, e.last);
            end
        end else begin
            chk("done_quiet", bus.done, 1'b0);
            chk("data_out_quiet", bus.data_out, 1'b0);
        end
    endtask

    task automatic push_model(input logic [W-1:0] pat, input int reps);
        logic [W-1:0] p;
        exp_t         e;
        p = pat;
        for (int r = 0; r <= reps; r++) begin
            for (int i = W - 1; i >= 0; i--) begin
                e.b    = p[i];
                e.last = 1'b0;
                sb.push_back(e);
            end
            if (PAR == 1) begin
                e.b    = ^p;
                e.last = 1'b0;
                sb.push_back(e);
            end
        end
        e = sb.pop_back();
        e.last = 1'b1;
        sb.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] pat, input int reps, input bit intrude);
        push_model(pat, reps);
        vld_cnt = 0;
        det_cnt = 0;
        hist    = 4'd0;
        chk("ready_before_load", bus.load_ready, 1'b1);
        bus.load_valid = 1'b1;
        bus.load_data  = pat;
        bus.load_reps  = R'(reps);
        step();
        bus.load_valid = 1'b0;
        chk("first_bit_latency", bus.data_vld, 1'b1);
        chk("busy_in_transfer", bus.busy, 1'b1);
        if (intrude) begin
            step();
            bus.load_valid = 1'b1;
            bus.load_data  = 4'b1111;
            bus.load_reps  = 4'd7;
            chk("ready_low_while_busy", bus.load_ready, 1'b0);
        end
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        bus.load_valid = 1'b0;
        chk_int("queue_drained", sb.size(), 0);
        step();
        chk("vld_gap_after_done", bus.data_vld, 1'b0);
        chk("busy_after_done", bus.busy, 1'b0);
        chk("ready_after_done", bus.load_ready, 1'b1);
        chk_int("vld_cycles", vld_cnt, (reps + 1) * (W + PAR));
    endtask

    initial begin
        exp_t e;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_reps  = '0;

        // Reset held for two cycles.
        step();
        step();
        chk("rst_ready", bus.load_ready, 1'b0);
        chk("rst_vld", bus.data_vld, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.load_ready, 1'b1);
        step();

        // Single pass, then three passes with an intruding load.
        send(4'b1010, 0, 1'b0);
        send(4'b1010, 2, 1'b1);
`ifndef SEQ_TX_PARITY_EN
        chk_int("det_1010_hits", det_cnt, 5);
`endif
        step();

        // Reset on the third bit of 1100 drops the rest with no done.
        e.last = 1'b0;
        e.b = 1'b1; sb.push_back(e);
        e.b = 1'b1; sb.push_back(e);
        e.b = 1'b0; sb.push_back(e);
        bus.load_valid = 1'b1;
        bus.load_data  = 4'b1100;
        bus.load_reps  = 4'd0;
        step();
        bus.load_valid = 1'b0;
        chk("rst_case_first_bit", bus.data_vld, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_vld", bus.data_vld, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_ready_in_rst", bus.load_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", bus.load_ready, 1'b1);
        chk_int("midrst_queue", sb.size(), 0);
        step();
        step();

        // Other patterns, including the all-ones repeat count.
        send(4'b1011, 1, 1'b0);
        send(4'b0110, 3, 1'b0);
        send(4'b1001, 15, 1'b0);
        send(4'b0001, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
